// File: rtl/mult_seq_param_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_param_if
// Purpose  : Start-and-wait handshake bundle for the sequential multiplier.
// Ports    : St, Signed, Multiplicando, Multiplicador (master -> slave)
//            Produto, Idle, Done                      (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface mult_seq_param_if #(
  parameter int WIDTH = 32
);
  logic                 St;
  logic                 Signed;
  logic [WIDTH-1:0]     Multiplicando;
  logic [WIDTH-1:0]     Multiplicador;
  logic [2*WIDTH-1:0]   Produto;
  logic                 Idle;
  logic                 Done;

  modport master (
    output St, Signed, Multiplicando, Multiplicador,
    input  Produto, Idle, Done
  );

  modport slave (
    input  St, Signed, Multiplicando, Multiplicador,
    output Produto, Idle, Done
  );
endinterface
`default_nettype wire

// File: rtl/mult_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_param
// Purpose  : Parametrised sequential shift-add multiplier with a full
//            2*WIDTH-bit product and per-operation signed/unsigned mode.
//            Magnitudes are multiplied unsigned; the sign is re-applied
//            when the result is written.
// Ports    : Clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - mult_seq_param_if.slave
//                     St/Signed/Multiplicando/Multiplicador sampled in IDLE
//                     Produto registered result, Idle = IDLE, Done = DONE
// Options  : MULT_EARLY_TERM_EN - when defined, CALC exits as soon as no
//            multiplier bits remain (data-dependent latency, <= WIDTH).
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq_param #(
  parameter int WIDTH = 32
) (
  input  wire logic             Clk,
  input  wire logic             rst_n,
  mult_seq_param_if.slave       bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0]   ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q,  state_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [CW-1:0]        cnt_q,    cnt_d;
  logic                 neg_q,    neg_d;
  logic [2*WIDTH-1:0]   prod_q,   prod_d;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     mplier_shr;
  logic                 calc_last;

  // Two's-complement absolute value; -2^(W-1) maps onto 2^(W-1), which is
  // still representable as a W-bit unsigned magnitude.
  always_comb begin
    mag_a = bus.Multiplicando;
    mag_b = bus.Multiplicador;
    if (bus.Signed && bus.Multiplicando[WIDTH-1]) begin
      mag_a = ~bus.Multiplicando + ONE_W;
    end
    if (bus.Signed && bus.Multiplicador[WIDTH-1]) begin
      mag_b = ~bus.Multiplicador + ONE_W;
    end
  end

  always_comb begin
    acc_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_shr = mplier_q >> 1;
`ifdef MULT_EARLY_TERM_EN
    calc_last  = (cnt_q == CNT_LAST) || (mplier_shr == '0);
`else
    calc_last  = (cnt_q == CNT_LAST);
`endif
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    prod_d   = prod_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.St) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = bus.Signed & (bus.Multiplicando[WIDTH-1] ^ bus.Multiplicador[WIDTH-1]);
          state_d  = ST_CALC;
`ifdef MULT_EARLY_TERM_EN
          // Nothing to accumulate: publish the zero product immediately.
          if (mag_b == '0) begin
            state_d = ST_DONE;
            prod_d  = '0;
          end
`endif
        end
      end

      ST_CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + CNT_ONE;
        if (calc_last) begin
          // Result is written on the same edge that enters DONE, so Done
          // and a valid Produto appear together.
          state_d = ST_DONE;
          prod_d  = neg_q ? (~acc_sum + ONE_2W) : acc_sum;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
    end
  end

  assign bus.Produto = prod_q;
  assign bus.Idle    = (state_q == ST_IDLE);
  assign bus.Done    = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq_param
// Purpose  : Directed self-checking bench for mult_seq_param (WIDTH=32).
//            Expected products are queued when an operation is launched and
//            compared when Done is observed. Latency is counted in rising
//            edges from the cycle St is raised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_seq_param;

  localparam int W = 32;

  logic Clk;
  logic rst_n;

  mult_seq_param_if #(.WIDTH(W)) bus ();

  mult_seq_param #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] last_prod = '0;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb;
    ea = sg ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = sg ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Rising edges from St assertion to Done=1.
  function automatic int exp_latency(input logic sg, input logic [W-1:0] b);
`ifdef MULT_EARLY_TERM_EN
    logic [W-1:0] m;
    int hi;
    m  = (sg && b[W-1]) ? (~b + 1'b1) : b;
    hi = -1;
    for (int i = 0; i < W; i++) if (m[i]) hi = i;
    return (hi < 0) ? 1 : hi + 2;
`else
    return W + 1;
`endif
  endfunction

  task automatic run_op(input string tag, input logic sg, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp, input bit repulse);
    int lat;
    bit seen;
    logic [2*W-1:0] got;
    @(negedge Clk);
    bus.St = 1'b1;
    bus.Signed = sg;
    bus.Multiplicando = a;
    bus.Multiplicador = b;
    sb.push_back(exp);
    lat  = 0;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge Clk);
      #1;
      lat++;
      // Scramble inputs after the sampling edge; they must not matter.
      bus.St = (repulse && k == 4);
      bus.Signed = ~sg;
      bus.Multiplicando = $urandom;
      bus.Multiplicador = $urandom;
      if (bus.Done === 1'b1) begin
        seen = 1;
      end else if (k == 0 && exp_latency(sg, b) > 1) begin
        check({tag, "_busy_idle"}, {63'd0, bus.Idle}, 64'd0);
        check({tag, "_prod_held"}, bus.Produto, last_prod);
      end
    end
    bus.St = 1'b0;
    check({tag, "_timeout"}, {63'd0, seen}, 64'd1);
    if (seen) begin
      check({tag, "_latency"}, 64'(lat), 64'(exp_latency(sg, b)));
      check({tag, "_idle_in_done"}, {63'd0, bus.Idle}, 64'd0);
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
        got = sb.pop_front();
        check({tag, "_produto"}, bus.Produto, got);
        last_prod = got;
      end
      @(posedge Clk);
      #1;
      check({tag, "_done_width"}, {63'd0, bus.Done}, 64'd0);
      check({tag, "_idle_after"}, {63'd0, bus.Idle}, 64'd1);
      check({tag, "_prod_stable"}, bus.Produto, last_prod);
    end
  endtask

  initial begin
    bus.St = 1'b0;
    bus.Signed = 1'b0;
    bus.Multiplicando = '0;
    bus.Multiplicador = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    // Asynchronous reset values before any clock edge.
    check("rst_async_idle", {63'd0, bus.Idle}, 64'd1);
    check("rst_async_done", {63'd0, bus.Done}, 64'd0);
    check("rst_async_prod", bus.Produto, 64'd0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    rst_n = 1'b1;
    @(negedge Clk);
    check("rst_idle", {63'd0, bus.Idle}, 64'd1);
    check("rst_done", {63'd0, bus.Done}, 64'd0);
    check("rst_prod", bus.Produto, 64'd0);

    run_op("u_a5x14",   1'b0, 32'h000000A5, 32'h00000014, 64'h0000000000000CE4, 1'b0);
    run_op("u_shift",   1'b0, 32'h12345678, 32'h00000002, 64'h000000002468ACF0, 1'b0);
    run_op("u_max",     1'b0, 32'hFFFFFFFF, 32'h000000FF, 64'h000000FEFFFFFF01, 1'b0);
    run_op("s_m1xff",   1'b1, 32'hFFFFFFFF, 32'h000000FF, 64'hFFFFFFFFFFFFFF01, 1'b0);
    run_op("s_minsq",   1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0);
    run_op("s_minx1",   1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000, 1'b0);
    run_op("s_repulse", 1'b1, 32'hFFFFFF85, 32'h0000007B, model(1'b1, 32'hFFFFFF85, 32'h0000007B), 1'b1);
    run_op("u_1234x2",  1'b0, 32'h00001234, 32'h00000002, 64'h0000000000002468, 1'b0);
    run_op("u_bzero",   1'b0, 32'hDEADBEEF, 32'h00000000, 64'h0, 1'b0);
    run_op("u_1xmsb",   1'b0, 32'h00000001, 32'h80000000, 64'h0000000080000000, 1'b0);
    run_op("s_negxneg", 1'b1, 32'hFFFF0001, 32'hFFFFFFF3, model(1'b1, 32'hFFFF0001, 32'hFFFFFFF3), 1'b0);
    for (int r = 0; r < 4; r++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = $urandom;
      rb = $urandom;
      rs = r[0];
      run_op("rand", rs, ra, rb, model(rs, ra, rb), 1'b0);
    end

    // Abort mid-CALC: asynchronous clear, no result afterwards.
    begin
      int done_cnt;
      @(negedge Clk);
      bus.St = 1'b1;
      bus.Signed = 1'b0;
      bus.Multiplicando = 32'h0000FFFF;
      bus.Multiplicador = 32'h0000FFFF;
      @(posedge Clk);
      #1 bus.St = 1'b0;
      repeat (9) @(posedge Clk);
      #3 rst_n = 1'b0;
      #1;
      check("abort_async_idle", {63'd0, bus.Idle}, 64'd1);
      check("abort_async_prod", bus.Produto, 64'd0);
      check("abort_async_done", {63'd0, bus.Done}, 64'd0);
      @(negedge Clk);
      rst_n = 1'b1;
      done_cnt = 0;
      repeat (W + 4) begin
        @(posedge Clk);
        #1;
        if (bus.Done === 1'b1) done_cnt++;
      end
      check("abort_no_done", 64'(done_cnt), 64'd0);
      check("abort_idle", {63'd0, bus.Idle}, 64'd1);
      check("abort_prod", bus.Produto, 64'd0);
      last_prod = '0;
    end

    run_op("post_abort", 1'b0, 32'h00000007, 32'h00000006, 64'd42, 1'b0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
